// File: rtl/wrtop_if.sv
// ---------------------------------------------------------------------------
// wrtop_if -- command and byte-memory write bundle for the wrtop initiator.
//
// Parameters:
//   ADDR_W  address width of addra / mem_a_waddr
//   NBYTES  bytes per burst; data word is 8*NBYTES bits
//
// Signals:
//   start, addra, dataa  burst request, base address and data word
//   wstrb                per-byte write mask (only when WR_STRB_EN is defined)
//   busy, done           burst status back to the requester
//   mem_a_waddr/wdata/wen byte write port towards the memory
//
// Modports:
//   master  requester side (drives the command, observes status and port)
//   slave   wrtop side (receives the command, drives status and port)
// ---------------------------------------------------------------------------
interface wrtop_if #(
    parameter int ADDR_W = 32,
    parameter int NBYTES = 4
);
    localparam int DATA_W = 8 * NBYTES;

    logic              start;
    logic [ADDR_W-1:0] addra;
    logic [DATA_W-1:0] dataa;
`ifdef WR_STRB_EN
    logic [NBYTES-1:0] wstrb;
`endif
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] mem_a_waddr;
    logic [7:0]        mem_a_wdata;
    logic              mem_a_wen;

    modport master (
        output start, addra, dataa,
`ifdef WR_STRB_EN
        output wstrb,
`endif
        input  busy, done, mem_a_waddr, mem_a_wdata, mem_a_wen
    );

    modport slave (
        input  start, addra, dataa,
`ifdef WR_STRB_EN
        input  wstrb,
`endif
        output busy, done, mem_a_waddr, mem_a_wdata, mem_a_wen
    );
endinterface

// File: rtl/wrtop.sv
// ---------------------------------------------------------------------------
// wrtop -- write-side burst initiator on byte memory port "a".
//
// On an accepted start (only in IDLE) the base address and the NBYTES-wide
// data word are latched, then NBYTES single-byte writes are issued one per
// cycle in little-endian order (byte 0 at base, address wraps mod 2^ADDR_W).
// A one-cycle done pulse follows the last byte, then the block returns to
// IDLE. start while busy is ignored; rst abandons a burst without done.
//
// Optional feature: define WR_STRB_EN to add a per-byte write mask (wstrb),
// latched with the data; masked bytes still take their cycle but keep
// mem_a_wen low.
//
// Ports:
//   clk  in   clock, all state updates on posedge
//   rst  in   synchronous reset, active high
//   bus  wrtop_if.slave: start/addra/dataa[/wstrb] in,
//        busy/done/mem_a_waddr/mem_a_wdata/mem_a_wen out
// ---------------------------------------------------------------------------
module wrtop #(
    parameter int ADDR_W = 32,
    parameter int NBYTES = 4
) (
    input  logic    clk,
    input  logic    rst,
    wrtop_if.slave  bus
);
    localparam int              DATA_W   = 8 * NBYTES;
    localparam int              CNT_W    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBYTES - 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SEND_WRITE = 2'd1,
        DONE       = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [ADDR_W-1:0] addr_buf_reg, addr_buf_next;
    logic [DATA_W-1:0] data_buf_reg, data_buf_next;
`ifdef WR_STRB_EN
    logic [NBYTES-1:0] strb_buf_reg, strb_buf_next;
`endif

    logic [7:0] data_bytes [NBYTES];
    logic       byte_en;

    // Byte lanes of the latched word, indexed by the byte counter.
    generate
        for (genvar gi = 0; gi < NBYTES; gi++) begin : g_lane
            assign data_bytes[gi] = data_buf_reg[8*gi +: 8];
        end
    endgenerate

`ifdef WR_STRB_EN
    assign byte_en = strb_buf_reg[cnt_reg];
`else
    assign byte_en = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            addr_buf_reg <= '0;
            data_buf_reg <= '0;
`ifdef WR_STRB_EN
            strb_buf_reg <= '0;
`endif
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            addr_buf_reg <= addr_buf_next;
            data_buf_reg <= data_buf_next;
`ifdef WR_STRB_EN
            strb_buf_reg <= strb_buf_next;
`endif
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        addr_buf_next = addr_buf_reg;
        data_buf_next = data_buf_reg;
`ifdef WR_STRB_EN
        strb_buf_next = strb_buf_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    state_next    = SEND_WRITE;
                    cnt_next      = '0;
                    addr_buf_next = bus.addra;
                    data_buf_next = bus.dataa;
`ifdef WR_STRB_EN
                    strb_buf_next = bus.wstrb;
`endif
                end
            end
            SEND_WRITE: begin
                // The counter parks on the last byte so that address and data
                // keep showing the final write through DONE and IDLE.
                if (cnt_reg == LAST_CNT) begin
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // All outputs come from registered state only; start never reaches them
    // combinationally.
    assign bus.busy        = (state_reg != IDLE);
    assign bus.done        = (state_reg == DONE);
    assign bus.mem_a_wen   = (state_reg == SEND_WRITE) && byte_en;
    assign bus.mem_a_waddr = addr_buf_reg + ADDR_W'(cnt_reg);
    assign bus.mem_a_wdata = data_bytes[cnt_reg];
endmodule

// File: tb/tb_wrtop.sv
// ---------------------------------------------------------------------------
// tb_wrtop -- self-checking bench for wrtop.
//
// A burst-timeline model (start edge, base, data, mask) predicts busy, done,
// wen, waddr and wdata after every clock edge; a byte memory records what
// the DUT commits and is checked against hand-computed literals.
// ---------------------------------------------------------------------------
module tb_wrtop;
    localparam int ADDR_W = 32;
    localparam int N      = 4;
    localparam int DATA_W = 8 * N;

    logic clk;
    logic rst;

    wrtop_if #(.ADDR_W(ADDR_W), .NBYTES(N)) bus ();

    wrtop #(.ADDR_W(ADDR_W), .NBYTES(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    // Memory seen by the DUT's write port.
    logic [7:0] mem [logic [31:0]];

    function automatic logic [8:0] rd(input logic [31:0] a);
        if (mem.exists(a)) return {1'b0, mem[a]};
        return 9'h100;
    endfunction

    // Burst-timeline model state.
    int                model_on    = 0;
    int                edge_n      = 0;
    int                accept_edge = 0;
    int                b_valid     = 0;
    int                b_start     = 0;
    logic [ADDR_W-1:0] b_base;
    logic [DATA_W-1:0] b_data;
    logic [N-1:0]      b_strb;
    logic [ADDR_W-1:0] last_addr;
    logic [7:0]        last_data;
    int                last_accept    = 0;
    int                last_done_edge = 0;
    int                done_cnt       = 0;

    initial begin
        logic              s_rst, s_start;
        logic [ADDR_W-1:0] s_addr;
        logic [DATA_W-1:0] s_data;
        logic [N-1:0]      s_strb;
        int                k;
        logic              e_busy, e_done, e_wen;
        forever begin
            @(posedge clk);
            s_rst   = rst;
            s_start = bus.start;
            s_addr  = bus.addra;
            s_data  = bus.dataa;
`ifdef WR_STRB_EN
            s_strb  = bus.wstrb;
`else
            s_strb  = '1;
`endif
            if (bus.mem_a_wen === 1'b1) mem[bus.mem_a_waddr] = bus.mem_a_wdata;
            edge_n++;
            #1;
            if (s_rst === 1'b1) begin
                model_on    = 1;
                b_valid     = 0;
                accept_edge = edge_n + 1;
                last_addr   = '0;
                last_data   = '0;
            end else if (model_on != 0 && s_start === 1'b1 && edge_n >= accept_edge) begin
                b_valid     = 1;
                b_start     = edge_n;
                b_base      = s_addr;
                b_data      = s_data;
                b_strb      = s_strb;
                accept_edge = edge_n + N + 2;
                last_accept = edge_n;
            end
            if (model_on != 0) begin
                k      = (b_valid != 0) ? (edge_n - b_start) : -1;
                e_busy = (k >= 0) && (k <= N);
                e_done = (k == N);
                e_wen  = 1'b0;
                if (k >= 0 && k < N) begin
                    last_addr = b_base + ADDR_W'(k);
                    last_data = 8'(b_data >> (8 * k));
                    e_wen     = b_strb[k];
                end
                chk("busy",  {63'd0, bus.busy},      {63'd0, e_busy});
                chk("done",  {63'd0, bus.done},      {63'd0, e_done});
                chk("wen",   {63'd0, bus.mem_a_wen}, {63'd0, e_wen});
                chk("waddr", 64'(bus.mem_a_waddr),   64'(last_addr));
                chk("wdata", 64'(bus.mem_a_wdata),   64'(last_data));
                if (bus.done === 1'b1) begin
                    done_cnt++;
                    last_done_edge = edge_n;
                end
            end
        end
    end

    // Issue a one-cycle start; called and returns on a negedge.
    task automatic burst(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        bus.start = 1'b1;
        bus.addra = a;
        bus.dataa = d;
`ifdef WR_STRB_EN
        bus.wstrb = s;
`else
        if (s != 4'hF) $display("note: mask %h unused in this build", s);
`endif
        @(negedge clk);
        bus.start = 1'b0;
        $display("burst addr=%h data=%h issued", a, d);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.addra = '0;
        bus.dataa = '0;
`ifdef WR_STRB_EN
        bus.wstrb = '1;
`endif
        repeat (2) @(negedge clk);
        chk("rst_busy",  {63'd0, bus.busy},      64'd0);
        chk("rst_done",  {63'd0, bus.done},      64'd0);
        chk("rst_wen",   {63'd0, bus.mem_a_wen}, 64'd0);
        chk("rst_waddr", 64'(bus.mem_a_waddr),   64'd0);
        chk("rst_wdata", 64'(bus.mem_a_wdata),   64'd0);
        rst = 1'b0;
        @(negedge clk);

        // 1: basic little-endian burst
        burst(32'h100, 32'hDDCCBBAA, 4'hF);
        repeat (6) @(negedge clk);
        chk("t1_latency", 64'(last_done_edge - last_accept), 64'd4);
        chk("t1_m100", 64'(rd(32'h100)), 64'h0AA);
        chk("t1_m101", 64'(rd(32'h101)), 64'h0BB);
        chk("t1_m102", 64'(rd(32'h102)), 64'h0CC);
        chk("t1_m103", 64'(rd(32'h103)), 64'h0DD);

        // 2: start held high, data changing every cycle
        d0 = done_cnt;
        bus.start = 1'b1;
        for (int i = 0; i < 18; i++) begin
            bus.addra = 32'h300 + 32'(16 * i);
            bus.dataa = 32'h01010101 * 32'(i);
            @(negedge clk);
        end
        bus.start = 1'b0;
        repeat (8) @(negedge clk);
        chk("t2_bursts", 64'(done_cnt - d0), 64'd3);
        chk("t2_m300", 64'(rd(32'h300)), 64'h000);
        chk("t2_m363", 64'(rd(32'h363)), 64'h006);
        chk("t2_m3c1", 64'(rd(32'h3C1)), 64'h00C);
        chk("t2_m310", 64'(rd(32'h310)), 64'h100);
        $display("back-to-back bursts: %0d done pulses", done_cnt - d0);

        // 3: address wrap
        burst(32'hFFFFFFFE, 32'h87654321, 4'hF);
        repeat (6) @(negedge clk);
        chk("t3_mfffe", 64'(rd(32'hFFFFFFFE)), 64'h021);
        chk("t3_mffff", 64'(rd(32'hFFFFFFFF)), 64'h043);
        chk("t3_m0000", 64'(rd(32'h00000000)), 64'h065);
        chk("t3_m0001", 64'(rd(32'h00000001)), 64'h087);

        // 4: reset during the second write cycle
        d0 = done_cnt;
        burst(32'h200, 32'h0D0C0B0A, 4'hF);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t4_wen",  {63'd0, bus.mem_a_wen}, 64'd0);
        chk("t4_busy", {63'd0, bus.busy},      64'd0);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("t4_nodone", 64'(done_cnt - d0), 64'd0);
        chk("t4_m201", 64'(rd(32'h201)), 64'h00B);
        chk("t4_m202", 64'(rd(32'h202)), 64'h100);
        chk("t4_m203", 64'(rd(32'h203)), 64'h100);
        burst(32'h210, 32'h1A2B3C4D, 4'hF);
        repeat (6) @(negedge clk);
        chk("t4_m210", 64'(rd(32'h210)), 64'h04D);
        chk("t4_m213", 64'(rd(32'h213)), 64'h01A);

        // 6: start pulses while busy are ignored
        burst(32'h400, 32'h11223344, 4'hF);
        for (int i = 0; i <= N; i++) begin
            bus.start = 1'b1;
            bus.addra = 32'h500;
            bus.dataa = 32'hFFFFFFFF;
            @(negedge clk);
        end
        bus.start = 1'b0;
        repeat (6) @(negedge clk);
        chk("t6_m500", 64'(rd(32'h500)), 64'h100);
        chk("t6_m400", 64'(rd(32'h400)), 64'h044);
        chk("t6_m403", 64'(rd(32'h403)), 64'h011);

`ifdef WR_STRB_EN
        // 5: masked burst and all-zero mask
        burst(32'h20, 32'h44332211, 4'b0101);
        repeat (6) @(negedge clk);
        chk("t5_latency", 64'(last_done_edge - last_accept), 64'd4);
        chk("t5_m20", 64'(rd(32'h20)), 64'h011);
        chk("t5_m21", 64'(rd(32'h21)), 64'h100);
        chk("t5_m22", 64'(rd(32'h22)), 64'h033);
        chk("t5_m23", 64'(rd(32'h23)), 64'h100);
        d0 = done_cnt;
        burst(32'h40, 32'hAABBCCDD, 4'b0000);
        repeat (6) @(negedge clk);
        chk("t5_zero_done", 64'(done_cnt - d0), 64'd1);
        chk("t5_m40", 64'(rd(32'h40)), 64'h100);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
